// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS data-memory responder.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/mips_dmem_array.sv
// Single-port synchronous word RAM: registered read, write enable, reset clear.
// An access outside 0..DEPTH-1 leaves memory untouched and returns zero.
module mips_dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic              in_range;
  logic [AW-1:0]     idx;

  assign in_range = (addr < DEPTH);
  assign idx      = addr[AW-1:0];

  // NOTE: the array is cleared by reset, so it maps to registers rather than a
  // reset-less RAM macro; that is the price of a guaranteed all-zero image.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else if (en) begin
      if (we && in_range) begin
        mem[idx] <= wdata;
        rdata    <= '0;
      end else if (!we && in_range) begin
        rdata <= mem[idx];
      end else begin
        rdata <= '0;
      end
    end
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// Valid/ready data-memory responder with a fixed number of wait states.
// Define MIPS_DMEM_STATS_EN to add saturating load/store completion counters.
module mips_dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH       = 100,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
`ifdef MIPS_DMEM_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  dmem_state_t       state;
  logic [3:0]        cnt;
  logic              cap_write;
  logic [WORD_W-1:0] cap_addr;
  logic [WORD_W-1:0] cap_wdata;

  logic              accept;
  logic              enter_resp;
  logic              acc_write;
  logic [WORD_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic              acc_err;

  assign accept = req_valid && req_ready;

  // With zero wait states the access happens straight from the request bus.
  always_comb begin
    enter_resp = 1'b0;
    acc_write  = cap_write;
    acc_addr   = cap_addr;
    acc_wdata  = cap_wdata;
    if (WAIT_CYCLES == 0) begin
      enter_resp = accept;
      acc_write  = req_write;
      acc_addr   = req_addr;
      acc_wdata  = req_wdata;
    end else begin
      enter_resp = (state == WAIT) && (cnt == 4'd1);
    end
  end

  assign acc_err = (acc_addr >= DEPTH);

  mips_dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (enter_resp),
    .we    (acc_write && !acc_err),
    .addr  (acc_addr),
    .wdata (acc_wdata),
    .rdata (resp_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      cnt        <= '0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_err   <= acc_err;
      end
    end
  end

`ifdef MIPS_DMEM_STATS_EN
  logic done;
  assign done = resp_valid && resp_ready && !resp_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (done) begin
      if (cap_write && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (!cap_write && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed bench: instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=0.
module tb_mips_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
`ifdef MIPS_DMEM_STATS_EN
  logic [15:0] rd_count [2];
  logic [15:0] wr_count [2];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_dmem_responder #(.DEPTH(100), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
`ifdef MIPS_DMEM_STATS_EN
    , .rd_count(rd_count[0]), .wr_count(wr_count[0])
`endif
  );

  mips_dmem_responder #(.DEPTH(100), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
`ifdef MIPS_DMEM_STATS_EN
    , .rd_count(rd_count[1]), .wr_count(wr_count[1])
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Runs one transaction on instance i; called and returning on a negedge.
  task automatic xact(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    while (!req_ready[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
    @(negedge clk);
    req_valid[i] = 1'b0;
    lat = 1;
    while (!resp_valid[i] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata[i];
    er = resp_err[i];
    resp_ready[i] = 1'b1;
    @(negedge clk);
    resp_ready[i] = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          acc;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0;   resp_ready[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready[0]), 32'd1);
    check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("rst_rdata", resp_rdata[0], 32'd0);
    check("rst_err", 32'(resp_err[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Store then load with two wait states.
    xact(0, 1'b1, 32'd5, 32'hDEADBEEF, rd, er, lat);
    check("sw5_lat", 32'(lat), 32'd3);
    check("sw5_rdata", rd, 32'd0);
    check("sw5_err", 32'(er), 32'd0);
    xact(0, 1'b0, 32'd5, 32'd0, rd, er, lat);
    check("lw5_lat", 32'(lat), 32'd3);
    check("lw5_rdata", rd, 32'hDEADBEEF);
    check("lw5_err", 32'(er), 32'd0);

    xact(0, 1'b1, 32'd3, 32'h12345678, rd, er, lat);
    xact(0, 1'b1, 32'd4, 32'hCAFEF00D, rd, er, lat);
    xact(0, 1'b0, 32'd3, 32'd0, rd, er, lat);
    check("lw3_rdata", rd, 32'h12345678);
    xact(0, 1'b0, 32'd4, 32'd0, rd, er, lat);
    check("lw4_rdata", rd, 32'hCAFEF00D);

    // Backpressure: response held while resp_ready stays low.
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'd0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_resp_valid", 32'(resp_valid[0]), 32'd1);
      check("bp_rdata", resp_rdata[0], 32'd0);
      check("bp_req_ready", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
    end
    resp_ready[0] = 1'b1;
    @(negedge clk);
    resp_ready[0] = 1'b0;
    check("bp_release", 32'(req_ready[0]), 32'd1);

    // Out-of-range accesses.
    xact(0, 1'b1, 32'd100, 32'd1, rd, er, lat);
    check("sw100_err", 32'(er), 32'd1);
    check("sw100_rdata", rd, 32'd0);
    xact(0, 1'b0, 32'd100, 32'd0, rd, er, lat);
    check("lw100_err", 32'(er), 32'd1);
    check("lw100_rdata", rd, 32'd0);
    xact(0, 1'b0, 32'd99, 32'd0, rd, er, lat);
    check("lw99_err", 32'(er), 32'd0);
    check("lw99_rdata", rd, 32'd0);

    // Reset while the store to address 7 is waiting.
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'd7; req_wdata[0] = 32'd9;
    @(negedge clk);
    req_valid[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", 32'(req_ready[0]), 32'd1);
    check("mid_rst_resp_valid", 32'(resp_valid[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);
`ifdef MIPS_DMEM_STATS_EN
    check("stats_rst_wr", 32'(wr_count[0]), 32'd0);
    check("stats_rst_rd", 32'(rd_count[0]), 32'd0);
`endif
    xact(0, 1'b0, 32'd7, 32'd0, rd, er, lat);
    check("lw7_rdata", rd, 32'd0);
    check("lw7_err", 32'(er), 32'd0);

    // Since reset: 1 load so far; add 3 stores, 1 load, 1 error.
    xact(0, 1'b1, 32'd1, 32'h11, rd, er, lat);
    xact(0, 1'b1, 32'd2, 32'h22, rd, er, lat);
    xact(0, 1'b1, 32'd98, 32'h98, rd, er, lat);
    xact(0, 1'b0, 32'd98, 32'd0, rd, er, lat);
    check("lw98_rdata", rd, 32'h98);
    xact(0, 1'b0, 32'd200, 32'd0, rd, er, lat);
    check("lw200_err", 32'(er), 32'd1);
`ifdef MIPS_DMEM_STATS_EN
    check("stats_wr", 32'(wr_count[0]), 32'd3);
    check("stats_rd", 32'(rd_count[0]), 32'd2);
`endif

    // Zero wait states.
    xact(1, 1'b1, 32'd10, 32'hA5A5A5A5, rd, er, lat);
    check("z_sw_lat", 32'(lat), 32'd1);
    xact(1, 1'b0, 32'd10, 32'd0, rd, er, lat);
    check("z_lw_lat", 32'(lat), 32'd1);
    check("z_lw_rdata", rd, 32'hA5A5A5A5);

    // Back-to-back with resp_ready high: one acceptance every two cycles.
    resp_ready[1] = 1'b1;
    req_valid[1]  = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'd10;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      check("z_b2b_ready", 32'(req_ready[1]), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (req_ready[1]) acc++;
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    check("z_b2b_count", 32'(acc), 32'd4);
    @(negedge clk);
    resp_ready[1] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
